// File: rtl/mul_rep_add_pkg.sv
// Shared types and defaults for the repeated-addition multiplier.
//   state_t       : controller state encoding
//   DEFAULT_WIDTH : default operand/product width
package mul_rep_add_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/mul_rep_add_if.sv
// Request/operand/result bundle between a requester and mul_rep_add.
//   start   : level request from the requester
//   data_in : operand bus (multiplicand, then multiplier)
//   product : result register
//   done    : completion flag, held until start drops
interface mul_rep_add_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic             done;

  modport master (
    output start,
    output data_in,
    input  product,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output product,
    output done
  );

endinterface

// File: rtl/mul_rep_add_dp.sv
// Datapath of the repeated-addition multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : operand bus
//   lda        : capture multiplicand into A
//   ldb        : capture multiplier into B
//   decb       : decrement B
//   clrp       : clear P (wins over ldp)
//   ldp        : P <= P + A (wraps modulo 2^WIDTH)
//   eqz        : B == 0
//   product    : P register
module mul_rep_add_dp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lda,
  input  logic             ldb,
  input  logic             decb,
  input  logic             clrp,
  input  logic             ldp,
  output logic             eqz,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] p_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
    end else if (lda) begin
      a_reg <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg <= '0;
    end else if (ldb) begin
      b_reg <= data_in;
    end else if (decb) begin
      b_reg <= b_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
    end else if (clrp) begin
      p_reg <= '0;
    end else if (ldp) begin
      p_reg <= p_reg + a_reg;
    end
  end

  assign eqz     = (b_reg == '0);
  assign product = p_reg;

endmodule

// File: rtl/mul_rep_add.sv
// Unsigned multiplier by repeated addition: controller FSM plus datapath.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus.start    : level request, sampled only in IDLE and DONE
//   bus.data_in  : multiplicand in LOAD_A, multiplier in LOAD_B
//   bus.product  : P register
//   bus.done     : high only in DONE; held until start drops
module mul_rep_add
  import mul_rep_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_rep_add_if.slave  bus
);

  state_t state;
  logic   done_reg;
  logic   lda;
  logic   ldb;
  logic   decb;
  logic   clrp;
  logic   ldp;
  logic   eqz;

  // done is registered alongside the state so it is a clean Moore output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD_A;
          end
        end
        LOAD_A: state <= LOAD_B;
        LOAD_B: state <= CALC;
        CALC: begin
          if (eqz) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state    <= IDLE;
            done_reg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    lda  = 1'b0;
    ldb  = 1'b0;
    decb = 1'b0;
    clrp = 1'b0;
    ldp  = 1'b0;
    case (state)
      LOAD_A: lda = 1'b1;
      LOAD_B: begin
        ldb  = 1'b1;
        clrp = 1'b1;
      end
      CALC: begin
        if (!eqz) begin
          ldp  = 1'b1;
          decb = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mul_rep_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (bus.data_in),
    .lda     (lda),
    .ldb     (ldb),
    .decb    (decb),
    .clrp    (clrp),
    .ldp     (ldp),
    .eqz     (eqz),
    .product (bus.product)
  );

  assign bus.done = done_reg;

endmodule

// File: tb/tb_mul_rep_add.sv
// Directed self-checking bench for mul_rep_add.
module tb_mul_rep_add;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mul_rep_add_if #(.WIDTH(16)) bus ();

  mul_rep_add #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in IDLE. Leaves it in DONE with start high.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit noisy);
    logic [15:0] prev;
    logic [15:0] want;
    bit          seen;
    prev = bus.product;
    bus.start   = 1'b1;
    bus.data_in = a;
    tick();                                   // edge 0
    check("p_held_e0", 32'(bus.product), 32'(prev));
    check("done_low_e0", 32'(bus.done), 32'd0);
    tick();                                   // edge 1: A captured
    check("p_held_e1", 32'(bus.product), 32'(prev));
    bus.data_in = b;
    tick();                                   // edge 2: B captured, P cleared
    check("p_clear_e2", 32'(bus.product), 32'd0);
    seen = 1'b0;
    for (int k = 3; k <= int'(b) + 12 && !seen; k++) begin
      if (noisy) begin
        bus.data_in = 16'($urandom);
        bus.start   = 1'($urandom);
      end
      tick();
      if (bus.done) begin
        seen = 1'b1;
        check("done_edge", 32'(k), 32'(int'(b) + 3));
      end else if (k <= int'(b) + 2) begin
        want = 16'(a * 16'(k - 2));
        check("p_step", 32'(bus.product), 32'(want));
      end else begin
        check("done_late", 32'(bus.done), 32'd1);
      end
    end
    if (!seen) check("done_timeout", 32'(bus.done), 32'd1);
    want = 16'(a * b);
    check("product", 32'(bus.product), 32'(want));
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (noisy) bus.data_in = 16'($urandom);
      tick();
      check("done_hold", 32'(bus.done), 32'd1);
      check("p_hold", 32'(bus.product), 32'(want));
    end
  endtask

  task automatic to_idle();
    logic [15:0] last;
    last = bus.product;
    bus.start = 1'b0;
    tick();
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_p_kept", 32'(bus.product), 32'(last));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b1;
    bus.data_in = 16'd55;

    // Reset held with start high: nothing moves.
    tick();
    tick();
    check("rst_p", 32'(bus.product), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    tick();
    check("rst_p2", 32'(bus.product), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_p", 32'(bus.product), 32'd0);

    run_mul(16'd17, 16'd5, 1'b0);           // 85, done at edge 8
    to_idle();
    run_mul(16'd9, 16'd0, 1'b0);            // zero multiplier
    to_idle();
    run_mul(16'd0, 16'd7, 1'b0);            // zero multiplicand
    to_idle();
    run_mul(16'hFFFF, 16'd3, 1'b0);         // wraps to 16'hFFFD
    to_idle();
    run_mul(16'd12, 16'd12, 1'b0);          // 144, old result held until LOAD_B
    to_idle();
    run_mul(16'd6, 16'd7, 1'b1);            // noisy bus and start during CALC/DONE
    to_idle();

    // Reset in the middle of CALC.
    bus.start   = 1'b1;
    bus.data_in = 16'd100;
    tick();
    tick();
    bus.data_in = 16'd50;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("mid_calc_p", 32'(bus.product), 32'd400);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_p", 32'(bus.product), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    check("abort_p_held", 32'(bus.product), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("abort_idle_done", 32'(bus.done), 32'd0);

    run_mul(16'd3, 16'd4, 1'b0);            // clean run after abort
    to_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
